// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, state encoding and types for the register-file write arbiter
package regfile_pkg;
  localparam int ADDR_WIDTH = 6;
  localparam int DATA_WIDTH = 16;
  localparam int NUM_REGS   = 64;
  localparam logic [ADDR_WIDTH:0] INIT_LAST = (ADDR_WIDTH + 1)'(NUM_REGS - 1);
  typedef enum logic {INIT, RUN} wr_state_t;
  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; ports Clock_i, Reset_i, Enable_i, Valid_i[1:0] in, Grant_o[1:0] out
module rr_arbiter2 (
  input  logic       Clock_i,
  input  logic       Reset_i,
  input  logic       Enable_i,
  input  logic [1:0] Valid_i,
  output logic [1:0] Grant_o
);
  logic prio_q, prio_d;
  always_comb begin
    Grant_o = !Enable_i ? 2'b00 : &Valid_i ? (prio_q ? 2'b10 : 2'b01) : Valid_i;
    // favour the requester that just lost: granted 0 -> 1, granted 1 -> 0
    prio_d = |Grant_o ? Grant_o[0] : prio_q;
  end
  always_ff @(posedge Clock_i) prio_q <= Reset_i ? 1'b0 : prio_d;
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: zero-initialises the register file, then round-robins its write port between two requesters
// Ports: Clock_i/Reset_i (sync, active-high); Req{0,1}Valid_i/Address_i/Data_i in, Req{0,1}Ready_o out;
//        InitDone_o; RfAddressA_o/RfWriteData_o/RfWriteEnable_o drive RegisterFile port A.
module regfile_write_arbiter
  import regfile_pkg::*;
(
  input  logic                  Clock_i,
  input  logic                  Reset_i,
  input  logic                  Req0Valid_i,
  input  logic [ADDR_WIDTH-1:0] Req0Address_i,
  input  logic [DATA_WIDTH-1:0] Req0Data_i,
  output logic                  Req0Ready_o,
  input  logic                  Req1Valid_i,
  input  logic [ADDR_WIDTH-1:0] Req1Address_i,
  input  logic [DATA_WIDTH-1:0] Req1Data_i,
  output logic                  Req1Ready_o,
  output logic                  InitDone_o,
  output logic [ADDR_WIDTH-1:0] RfAddressA_o,
  output logic [DATA_WIDTH-1:0] RfWriteData_o,
  output logic                  RfWriteEnable_o
);
  wr_state_t state_q, state_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  reg_addr_t addr_q, addr_d;
  reg_data_t data_q, data_d;
  logic we_q, we_d, done_q, done_d;
  logic [1:0] grant;
  // Reset gating keeps Ready low in any cycle where Reset is sampled high
  rr_arbiter2 u_arb (
    .Clock_i  (Clock_i),
    .Reset_i  (Reset_i),
    .Enable_i (state_q == RUN && !Reset_i),
    .Valid_i  ({Req1Valid_i, Req0Valid_i}),
    .Grant_o  (grant)
  );
  assign Req0Ready_o     = grant[0];
  assign Req1Ready_o     = grant[1];
  assign InitDone_o      = done_q;
  assign RfAddressA_o    = addr_q;
  assign RfWriteData_o   = data_q;
  assign RfWriteEnable_o = we_q;
  always_comb begin
    state_d = (state_q == INIT && cnt_q == INIT_LAST) ? RUN : state_q;
    cnt_d   = state_q == INIT ? cnt_q + 1'b1 : cnt_q;
    we_d    = state_q == INIT || |grant;
    // with no grant the address/data hold so port A keeps showing the last written register
    addr_d  = state_q == INIT ? cnt_q[ADDR_WIDTH-1:0] : grant[1] ? Req1Address_i : grant[0] ? Req0Address_i : addr_q;
    data_d  = state_q == INIT ? '0 : grant[1] ? Req1Data_i : grant[0] ? Req0Data_i : data_q;
    done_d  = state_q == RUN;
  end
  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed and random checks of the write arbiter against a cycle-level reference model
module tb_regfile_write_arbiter;
  logic Clock = 1'b0;
  logic Reset, v0, v1, r0, r1, done, we;
  logic [5:0] a0, a1, ra;
  logic [15:0] d0, d1, rd;
  int n_assert = 0, n_fail = 0;
  logic m_init = 1'b1, m_prio = 1'b0, m_we = 1'b0, m_done = 1'b0, m_g0 = 1'b0, m_g1 = 1'b0;
  logic obs_r0, obs_r1;
  int m_cnt = 0;
  logic [5:0] m_addr = '0;
  logic [15:0] m_data = '0;
  logic [15:0] m_regs [64];
  logic [15:0] tb_rf [64];

  regfile_write_arbiter dut (
    .Clock_i(Clock), .Reset_i(Reset),
    .Req0Valid_i(v0), .Req0Address_i(a0), .Req0Data_i(d0), .Req0Ready_o(r0),
    .Req1Valid_i(v1), .Req1Address_i(a1), .Req1Data_i(d1), .Req1Ready_o(r1),
    .InitDone_o(done), .RfAddressA_o(ra), .RfWriteData_o(rd), .RfWriteEnable_o(we)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) if (we) tb_rf[ra] <= rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: check Ready, advance model, check registered outputs at the next negedge
  task automatic cyc();
    #1;
    m_g0 = !m_init && !Reset && v0 && (!v1 || !m_prio);
    m_g1 = !m_init && !Reset && v1 && (!v0 || m_prio);
    obs_r0 = r0;
    obs_r1 = r1;
    chk("ready0", r0, m_g0);
    chk("ready1", r1, m_g1);
    if (Reset) begin
      m_init = 1; m_cnt = 0; m_prio = 0; m_we = 0; m_addr = 0; m_data = 0; m_done = 0;
    end else if (m_init) begin
      m_we = 1; m_addr = m_cnt[5:0]; m_data = 0; m_regs[m_cnt] = 0;
      m_init = (m_cnt != 63);
      m_cnt++;
    end else begin
      m_done = 1;
      m_we = m_g0 | m_g1;
      if (m_g0) begin m_addr = a0; m_data = d0; m_regs[a0] = d0; m_prio = 1; end
      if (m_g1) begin m_addr = a1; m_data = d1; m_regs[a1] = d1; m_prio = 0; end
    end
    @(posedge Clock);
    @(negedge Clock);
    chk("we", we, m_we);
    chk("addr", ra, m_addr);
    chk("data", rd, m_data);
    chk("init_done", done, m_done);
  endtask

  initial begin
    Reset = 1; v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    @(negedge Clock);
    cyc(); cyc();
    chk("rst_we", we, 0);
    chk("rst_done", done, 0);
    Reset = 0;
    for (int i = 0; i < 64; i++) begin
      cyc();
      chk("t1_init_addr", ra, i);
      chk("t1_init_we", we, 1);
    end
    chk("t1_not_done_yet", done, 0);
    cyc();
    chk("t1_done", done, 1);
    chk("t1_we_off", we, 0);

    v0 = 1; a0 = 6'd15; d0 = 16'hF0F0;
    cyc();
    chk("t2_ready_same_cycle", obs_r0, 1);
    chk("t2_addr", ra, 15);
    chk("t2_data", rd, 16'hF0F0);
    v0 = 0;
    cyc();
    chk("t2_we_pulse_end", we, 0);

    v1 = 1; a1 = 6'd22; d1 = 16'h2222;
    cyc();
    chk("t3_pre_grant1", obs_r1, 1);
    v0 = 1; a0 = 6'd3; d0 = 16'h1111;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t3_grant0_alt", obs_r0, (i % 2 == 0));
      chk("t3_grant1_alt", obs_r1, (i % 2 == 1));
      chk("t3_addr_alt", ra, (i % 2 == 0) ? 22'd3 : 22'd22);
    end

    a0 = 6'd7; d0 = 16'hAAAA; a1 = 6'd7; d1 = 16'h5555;
    cyc();
    chk("t4_first", rd, 16'hAAAA);
    v0 = 0;
    cyc();
    chk("t4_second", rd, 16'h5555);
    v1 = 0;
    cyc();
    chk("t4_rf7", tb_rf[7], 16'h5555);

    v0 = 1; a0 = 6'd9; d0 = 16'h0909;
    cyc();
    v0 = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t6_idle_we", we, 0);
      chk("t6_hold_addr", ra, 9);
    end

    Reset = 1;
    cyc();
    Reset = 0;
    v1 = 1; a1 = 6'd40; d1 = 16'h1234;
    repeat (30) cyc();
    chk("t5_cnt30_addr", ra, 29);
    Reset = 1;
    cyc();
    Reset = 0;
    cyc();
    chk("t5_restart_addr", ra, 0);
    chk("t5_restart_we", we, 1);
    repeat (63) cyc();
    chk("t5_last_init", ra, 63);
    chk("t5_done_low", done, 0);
    cyc();
    chk("t5_held_req_granted", obs_r1, 1);
    chk("t5_held_req_addr", ra, 40);
    chk("t5_done", done, 1);
    v1 = 0;
    cyc();

    for (int i = 0; i < 400; i++) begin
      if (!v0 || m_g0) begin v0 = 1'($urandom_range(0, 1)); a0 = 6'($urandom); d0 = 16'($urandom); end
      else if ($urandom_range(0, 7) == 0) v0 = 0;
      if (!v1 || m_g1) begin v1 = 1'($urandom_range(0, 1)); a1 = 6'($urandom); d1 = 16'($urandom); end
      else if ($urandom_range(0, 7) == 0) v1 = 0;
      Reset = (i == 200);
      cyc();
    end
    Reset = 0; v0 = 0; v1 = 0;
    cyc(); cyc();
    for (int i = 0; i < 64; i++) chk("rf_contents", tb_rf[i], m_regs[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
